// File: rtl/regbank_wr_arbiter.sv
// rtl/regbank_wr_arbiter.sv - register bank write-port owner: reset sweep, A/B round-robin arbitration, link path
module regbank_wr_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              start,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_gnt,
    input  logic              ra_req,
    input  logic [DATA_W-1:0] ra_data,
    output logic              we,
    output logic [ADDR_W-1:0] wr,
    output logic [DATA_W-1:0] data,
    output logic              ra_we,
    output logic [DATA_W-1:0] pc_4,
    output logic              init_done,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(31);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic               ptr_q, ptr_d;       // 0 = A has priority, 1 = B
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  wr_q, wr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               a_gnt_q, a_gnt_d;
    logic               b_gnt_q, b_gnt_d;
    logic               ra_we_q, ra_we_d;
    logic [DATA_W-1:0]  pc_4_q, pc_4_d;
    logic               init_done_q, init_done_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    // A requester whose grant is showing this cycle has already been served,
    // so it is not a candidate; a candidate aiming at r31 is held off while
    // the link path writes r31.
    logic a_cand, b_cand, a_elig, b_elig, a_win, b_win;
    assign a_cand = a_req && !a_gnt_q;
    assign b_cand = b_req && !b_gnt_q;
    assign a_elig = a_cand && !(ra_req && (a_addr == LINK_IDX));
    assign b_elig = b_cand && !(ra_req && (b_addr == LINK_IDX));
    assign a_win  = a_elig && (!b_elig || !ptr_q);
    assign b_win  = b_elig && !a_win;

    // Next-state: clear sweep in INIT, then registered arbitration in RUN
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        we_d        = 1'b0;
        wr_d        = '0;
        data_d      = '0;
        a_gnt_d     = 1'b0;
        b_gnt_d     = 1'b0;
        ra_we_d     = 1'b0;
        pc_4_d      = '0;
        init_done_d = init_done_q;
        stall_d     = stall_q;
        case (state_q)
            S_INIT: begin
                we_d  = 1'b1;
                wr_d  = cnt_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                ra_we_d = ra_req;
                pc_4_d  = ra_req ? ra_data : '0;
                if (a_win) begin
                    we_d    = 1'b1;
                    wr_d    = a_addr;
                    data_d  = a_data;
                    a_gnt_d = 1'b1;
                    ptr_d   = 1'b1;
                end else if (b_win) begin
                    we_d    = 1'b1;
                    wr_d    = b_addr;
                    data_d  = b_data;
                    b_gnt_d = 1'b1;
                    ptr_d   = 1'b0;
                end
                if (((a_cand && !a_win) || (b_cand && !b_win)) && (stall_q != {CNT_W{1'b1}}))
                    stall_d = stall_q + 1'b1;
            end
        endcase
    end

    // State and registered bank-side outputs; start low aborts everything
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            ptr_q       <= 1'b0;
            we_q        <= 1'b0;
            wr_q        <= '0;
            data_q      <= '0;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            ra_we_q     <= 1'b0;
            pc_4_q      <= '0;
            init_done_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            we_q        <= we_d;
            wr_q        <= wr_d;
            data_q      <= data_d;
            a_gnt_q     <= a_gnt_d;
            b_gnt_q     <= b_gnt_d;
            ra_we_q     <= ra_we_d;
            pc_4_q      <= pc_4_d;
            init_done_q <= init_done_d;
            stall_q     <= stall_d;
        end
    end

    assign a_gnt     = a_gnt_q;
    assign b_gnt     = b_gnt_q;
    assign we        = we_q;
    assign wr        = wr_q;
    assign data      = data_q;
    assign ra_we     = ra_we_q;
    assign pc_4      = pc_4_q;
    assign init_done = init_done_q;
    assign stall_cnt = stall_q;

endmodule
